// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared widths, encodings and FSM/control types for the fetch-stage PC controller.
package fetch_pc_ctrl_pkg;

  localparam int unsigned PC_W    = 7;
  localparam int unsigned INSTR_W = 16;

  localparam logic [INSTR_W-1:0] NOP     = '0;
  localparam logic [INSTR_W-1:0] HALT_OP = '1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  // IF/ID register control: hold, load new entry, squash to a bubble, or
  // retire the held entry (drop valid, keep contents).
  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_LOAD   = 2'd1,
    IFID_BUBBLE = 2'd2,
    IFID_RETIRE = 2'd3
  } ifid_op_t;

  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return instr == HALT_OP;
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Fetch-stage bus: sumador loop, instruction memory, pipeline controls and IF/ID outputs.
interface fetch_pc_ctrl_if;
  import fetch_pc_ctrl_pkg::*;

  logic [PC_W-1:0]    pc_inc;
  logic [INSTR_W-1:0] instr_in;
  logic               stall;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;
  logic               flush;

  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    if_id_pc;
  logic [INSTR_W-1:0] if_id_instr;
  logic               if_id_valid;
  logic               halted;

  modport slave (
    input  pc_inc, instr_in, stall, branch_taken, branch_target, flush,
    output pc, if_id_pc, if_id_instr, if_id_valid, halted
  );

  modport master (
    output pc_inc, instr_in, stall, branch_taken, branch_target, flush,
    input  pc, if_id_pc, if_id_instr, if_id_valid, halted
  );

endinterface

// File: rtl/fetch_pc_ctrl_if_id.sv
// IF/ID pipeline register with hold/load/bubble/retire control and async active-low reset.
module if_id_reg
  import fetch_pc_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  ifid_op_t           op,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr,
  output logic               valid
);

  // A bubble leaves the PC field untouched; only instr/valid mark it empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= '0;
      instr <= NOP;
      valid <= 1'b0;
    end else begin
      unique case (op)
        IFID_LOAD: begin
          pc    <= pc_in;
          instr <= instr_in;
          valid <= 1'b1;
        end
        IFID_BUBBLE: begin
          instr <= NOP;
          valid <= 1'b0;
        end
        IFID_RETIRE: valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC register, RUN/HALT FSM and redirect/stall/flush priority; drives the IF/ID register.
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  fetch_pc_ctrl_if.slave bus
);

  state_t             state, state_nxt;
  logic [PC_W-1:0]    pc_q, pc_nxt;
  ifid_op_t           ifid_op;
  logic [PC_W-1:0]    ifid_pc;
  logic [INSTR_W-1:0] ifid_instr;
  logic               ifid_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      pc_q  <= '0;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
    end
  end

  // Flush outranks halt detection: a squashed HALT_OP never stops fetch.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    ifid_op   = IFID_HOLD;
    unique case (state)
      ST_RUN: begin
        if (bus.branch_taken) begin
          pc_nxt  = bus.branch_target;
          ifid_op = IFID_BUBBLE;
        end else if (bus.stall) begin
          if (bus.flush) ifid_op = IFID_BUBBLE;
        end else if (bus.flush) begin
          pc_nxt  = bus.pc_inc;
          ifid_op = IFID_BUBBLE;
        end else if (is_halt(bus.instr_in)) begin
          ifid_op   = IFID_LOAD;
          state_nxt = ST_HALT;
        end else begin
          pc_nxt  = bus.pc_inc;
          ifid_op = IFID_LOAD;
        end
      end
      ST_HALT: ifid_op = IFID_RETIRE;
      default: state_nxt = ST_RUN;
    endcase
  end

  if_id_reg u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .op       (ifid_op),
    .pc_in    (pc_q),
    .instr_in (bus.instr_in),
    .pc       (ifid_pc),
    .instr    (ifid_instr),
    .valid    (ifid_valid)
  );

  assign bus.pc          = pc_q;
  assign bus.if_id_pc    = ifid_pc;
  assign bus.if_id_instr = ifid_instr;
  assign bus.if_id_valid = ifid_valid;
  assign bus.halted      = (state == ST_HALT);

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Scoreboard bench for fetch_pc_ctrl: sumador and instruction memory modelled around the DUT.
module tb_fetch_pc_ctrl;
  import fetch_pc_ctrl_pkg::*;

  typedef struct {
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    ipc;
    logic [INSTR_W-1:0] instr;
    logic               valid;
    logic               halted;
  } exp_t;

  logic clk;
  logic rst_n;
  logic halt_inject;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];

  logic [PC_W-1:0]    m_pc, m_ipc;
  logic [INSTR_W-1:0] m_instr;
  logic               m_valid, m_halt;

  fetch_pc_ctrl_if bus ();

  fetch_pc_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [INSTR_W-1:0] mem(input logic [PC_W-1:0] a);
    return {a, 2'b10, ~a};
  endfunction

  assign bus.pc_inc   = bus.pc + 7'd1;
  assign bus.instr_in = (halt_inject && bus.pc == 7'd9) ? HALT_OP : mem(bus.pc);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = '0; m_ipc = '0; m_instr = NOP; m_valid = 1'b0; m_halt = 1'b0;
  endtask

  task automatic model_edge();
    logic [INSTR_W-1:0] fetched;
    fetched = (halt_inject && m_pc == 7'd9) ? HALT_OP : mem(m_pc);
    if (m_halt) begin
      m_valid = 1'b0;
    end else if (bus.branch_taken) begin
      m_pc = bus.branch_target; m_instr = NOP; m_valid = 1'b0;
    end else if (bus.stall) begin
      if (bus.flush) begin m_instr = NOP; m_valid = 1'b0; end
    end else if (bus.flush) begin
      m_pc = m_pc + 7'd1; m_instr = NOP; m_valid = 1'b0;
    end else begin
      m_ipc = m_pc; m_instr = fetched; m_valid = 1'b1;
      if (fetched == HALT_OP) m_halt = 1'b1;
      else m_pc = m_pc + 7'd1;
    end
  endtask

  // Drive-side: push the model's prediction, then let one edge happen and score it.
  task automatic step(input string tag);
    exp_t e, g;
    model_edge();
    e.pc = m_pc; e.ipc = m_ipc; e.instr = m_instr; e.valid = m_valid; e.halted = m_halt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    g = sb_q.pop_front();
    check({tag, ".pc"},     32'(bus.pc),          32'(g.pc));
    check({tag, ".ipc"},    32'(bus.if_id_pc),    32'(g.ipc));
    check({tag, ".instr"},  32'(bus.if_id_instr), 32'(g.instr));
    check({tag, ".valid"},  32'(bus.if_id_valid), 32'(g.valid));
    check({tag, ".halted"}, 32'(bus.halted),      32'(g.halted));
  endtask

  task automatic set_in(input logic st, input logic br, input logic [PC_W-1:0] tgt, input logic fl);
    bus.stall = st; bus.branch_taken = br; bus.branch_target = tgt; bus.flush = fl;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".pc"},     32'(bus.pc),          32'd0);
    check({tag, ".ipc"},    32'(bus.if_id_pc),    32'd0);
    check({tag, ".instr"},  32'(bus.if_id_instr), 32'(NOP));
    check({tag, ".valid"},  32'(bus.if_id_valid), 32'd0);
    check({tag, ".halted"}, 32'(bus.halted),      32'd0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; halt_inject = 1'b0;
    set_in(1'b0, 1'b0, '0, 1'b0);
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_vals("reset");
    @(negedge clk) rst_n = 1'b1;

    // 1: free run, pc 0..3
    for (int i = 1; i <= 3; i++) begin
      step("run");
      check("run.pc_seq", 32'(bus.pc), 32'(i));
    end

    // 2: stall two cycles at pc=3, then resume to 5
    set_in(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step("stall");
      check("stall.pc", 32'(bus.pc), 32'd3);
      check("stall.ipc", 32'(bus.if_id_pc), 32'd2);
    end
    set_in(1'b0, 1'b0, '0, 1'b0);
    step("resume");
    step("resume");
    check("resume.pc", 32'(bus.pc), 32'd5);

    // 3: branch with stall at pc=5
    set_in(1'b1, 1'b1, 7'h40, 1'b0);
    step("br_stall");
    check("br_stall.pc", 32'(bus.pc), 32'h40);
    check("br_stall.valid", 32'(bus.if_id_valid), 32'd0);
    set_in(1'b0, 1'b0, '0, 1'b0);
    step("br_next");
    check("br_next.ipc", 32'(bus.if_id_pc), 32'h40);

    // 4: branch to 0x7E and wrap
    set_in(1'b0, 1'b1, 7'h7E, 1'b0);
    step("br_wrap");
    set_in(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) step("wrap");
    check("wrap.pc", 32'(bus.pc), 32'h02);
    check("wrap.ipc", 32'(bus.if_id_pc), 32'h01);

    // flush alone advances pc; flush with stall bubbles but holds pc
    set_in(1'b0, 1'b0, '0, 1'b1);
    step("flush");
    set_in(1'b0, 1'b0, '0, 1'b0);
    step("post_flush");
    set_in(1'b1, 1'b0, '0, 1'b1);
    step("flush_stall");
    set_in(1'b0, 1'b0, '0, 1'b0);
    step("post_fs");

    // 5: halt at pc=9
    set_in(1'b0, 1'b1, 7'd9, 1'b0);
    step("br_to9");
    set_in(1'b0, 1'b0, '0, 1'b0);
    halt_inject = 1'b1;
    step("halt");
    check("halt.instr", 32'(bus.if_id_instr), 32'(HALT_OP));
    check("halt.pc", 32'(bus.pc), 32'd9);
    for (int i = 0; i < 10; i++) begin
      set_in(1'(i % 2), 1'(i == 3), 7'h22, 1'(i == 5));
      step("halted");
    end
    check("halted.valid", 32'(bus.if_id_valid), 32'd0);
    halt_inject = 1'b0;
    set_in(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk) rst_n = 1'b0;
    #1 check_reset_vals("halt_rst");
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    step("after_halt");
    step("after_halt");

    // 6: async reset mid-cycle during a branch
    set_in(1'b0, 1'b1, 7'h33, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    model_reset();
    set_in(1'b0, 1'b0, '0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    step("post_async");
    step("post_async");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
